// File: rtl/vend_pkg.sv
// Shared definitions for the vending change dispenser: change codes,
// FSM state type and the change-code to coin-count mapping.
package vend_pkg;

    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_5    = 2'b01;
    localparam logic [1:0] CHG_10   = 2'b10;
    localparam logic [1:0] CHG_RSVD = 2'b11;

    typedef logic [2:0] disp_state_t;

    localparam disp_state_t ST_IDLE  = 3'd0;
    localparam disp_state_t ST_PROD  = 3'd1;
    localparam disp_state_t ST_EJECT = 3'd2;
    localparam disp_state_t ST_WAIT  = 3'd3;
    localparam disp_state_t ST_DONE  = 3'd4;
    localparam disp_state_t ST_FAULT = 3'd5;

    // Number of Rs5 coins owed for a change code; the reserved code owes nothing.
    function automatic logic [1:0] chg_coins(input logic [1:0] code);
        case (code)
            CHG_5:             return 2'd1;
            CHG_10:            return 2'd2;
            CHG_NONE, CHG_RSVD: return 2'd0;
            default:           return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module pulse_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Product and Rs5 change dispenser sequencer with hopper sensor supervision.
// Define CHG_RETRY_EN to re-eject a missing coin up to MAX_RETRY times before faulting.
//
//   state | meaning
//   IDLE  | waiting for req_valid
//   PROD  | product motor driven for PULSE_W cycles
//   EJECT | Rs5 hopper actuator driven for PULSE_W cycles
//   WAIT  | waiting up to TIMEOUT cycles for coin_sense
//   DONE  | one-cycle completion pulse
//   FAULT | hopper failure, held until clr_fault
module change_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_W   = 4,
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       vend,
    input  logic [1:0] change,
    input  logic       coin_sense,
    input  logic       clr_fault,
    output logic       busy,
    output logic       prod_motor,
    output logic       coin_eject,
    output logic       done,
    output logic       fault
);

    if (PULSE_W < 1 || PULSE_W > 255 || TIMEOUT < 2 || TIMEOUT > 65535 ||
        MAX_RETRY < 0 || MAX_RETRY > 7) begin : g_param_check
        $error("change_dispenser: parameter out of legal range");
    end

    // Timer holds N-1 on entry so a state lasts exactly N cycles.
    localparam logic [15:0] PULSE_LD = 16'(PULSE_W - 1);
    localparam logic [15:0] WAIT_LD  = 16'(TIMEOUT - 1);

    disp_state_t state_q, state_d;
    logic [1:0]  coins_q, coins_d;
    logic        busy_q, busy_d;
    logic        prod_q, prod_d;
    logic        eject_q, eject_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;

    logic        tmr_load;
    logic [15:0] tmr_val;
    logic        tmr_expire;
    logic        retry_ok;

`ifdef CHG_RETRY_EN
    localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);
    logic [2:0] retry_q, retry_d;
    assign retry_ok = (retry_q < RETRY_LIM);
`else
    assign retry_ok = 1'b0;
`endif

    pulse_timer #(.W(16)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        coins_d  = coins_q;
        tmr_load = 1'b0;
        tmr_val  = PULSE_LD;
`ifdef CHG_RETRY_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    coins_d  = chg_coins(change);
                    tmr_load = 1'b1;
`ifdef CHG_RETRY_EN
                    retry_d  = 3'd0;
`endif
                    if (vend) begin
                        state_d = ST_PROD;
                    end else if (chg_coins(change) != 2'd0) begin
                        state_d = ST_EJECT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_PROD: begin
                if (tmr_expire) begin
                    if (coins_q != 2'd0) begin
                        state_d  = ST_EJECT;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_EJECT: begin
                if (tmr_expire) begin
                    state_d  = ST_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = WAIT_LD;
                end
            end
            ST_WAIT: begin
                // A coin arriving on the timeout cycle still counts as delivered.
                if (coin_sense) begin
                    coins_d = coins_q - 2'd1;
`ifdef CHG_RETRY_EN
                    retry_d = 3'd0;
`endif
                    if (coins_q == 2'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_EJECT;
                        tmr_load = 1'b1;
                    end
                end else if (tmr_expire) begin
                    if (retry_ok) begin
                        state_d  = ST_EJECT;
                        tmr_load = 1'b1;
`ifdef CHG_RETRY_EN
                        retry_d  = retry_q + 3'd1;
`endif
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (clr_fault) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        prod_d  = (state_d == ST_PROD);
        eject_d = (state_d == ST_EJECT);
        done_d  = (state_d == ST_DONE);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            coins_q <= 2'd0;
            busy_q  <= 1'b0;
            prod_q  <= 1'b0;
            eject_q <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            coins_q <= coins_d;
            busy_q  <= busy_d;
            prod_q  <= prod_d;
            eject_q <= eject_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

`ifdef CHG_RETRY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retry_q <= 3'd0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    assign busy       = busy_q;
    assign prod_motor = prod_q;
    assign coin_eject = eject_q;
    assign done       = done_q;
    assign fault      = fault_q;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter PULSE_W, default 4: actuator pulse width in cycles, legal range 1..255.
REQ-002 Parameter TIMEOUT, default 64: cycles allowed for coin_sense after an eject pulse, legal range 2..65535.
REQ-003 Parameter MAX_RETRY, default 2: re-eject attempts per coin before fault, legal range 0..7.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  dispense request strobe; sampled only in IDLE.
REQ-007 vend  input  1  dispense one product with this request.
REQ-008 change  input  2  change code: 00 none, 01 = Rs5, 10 = Rs10, 11 reserved.
REQ-009 coin_sense  input  1  hopper sensor, one-cycle pulse per coin delivered.
REQ-010 clr_fault  input  1  clears FAULT.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 prod_motor  output  1  product actuator drive.
REQ-013 coin_eject  output  1  Rs5 hopper actuator drive.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 fault  output  1  hopper failure, held high.

Function
REQ-016 States: IDLE, PROD, EJECT, WAIT, DONE, FAULT.
REQ-017 IDLE with req_valid=1: latch vend; latch coin count (00→0, 01→1, 10→2, 11→0); clear the retry count; go to PROD if vend=1, else EJECT if count>0, else DONE.
REQ-018 req_valid outside IDLE is ignored; busy=1 tells the requester to hold off.
REQ-019 PROD: prod_motor=1 for exactly PULSE_W cycles; then EJECT if count>0, else DONE.
REQ-020 EJECT: coin_eject=1 for exactly PULSE_W cycles; then WAIT with the timeout counter cleared.
REQ-021 WAIT with coin_sense=1: decrement count and clear the retry count; go to DONE if the new count is 0, else EJECT.
REQ-022 WAIT at TIMEOUT cycles elapsed with no coin_sense: if retry<MAX_RETRY, increment retry and go to EJECT; else go to FAULT.
REQ-023 coin_sense and timeout in the same cycle: coin_sense wins.
REQ-024 coin_sense in any state other than WAIT is ignored.
REQ-025 DONE: done=1 for one cycle, then IDLE.
REQ-026 FAULT: fault=1; all actuators are 0; stay until clr_fault=1, then go to IDLE with fault=0 on the next cycle; req_valid is ignored.
REQ-027 All outputs are registered; no output depends combinationally on an input.
REQ-028 Request-to-prod_motor latency is 1 cycle; coin_eject rises 1 cycle after the last cycle of PROD, or after the acceptance cycle when vend=0.

Reset
REQ-029 rst=0 forces IDLE asynchronously and clears all counters.
REQ-030 During reset, busy, prod_motor, coin_eject, done and fault are all 0.
REQ-031 Reset asserted mid-pulse drops the actuators immediately; the interrupted request is discarded.

Configuration
REQ-032 Macro CHG_RETRY_EN defined: the retry behaviour of REQ-022 applies.
REQ-033 Macro CHG_RETRY_EN undefined: the first timeout goes to FAULT; MAX_RETRY is ignored and no retry counter is built.

Structure
REQ-034 Shared package vend_pkg holds the change-code constants (CHG_NONE, CHG_5, CHG_10, CHG_RSVD) and the dispenser state typedef.
REQ-035 Sub-module pulse_timer (load, count-down, expire flag) serves both the pulse width and the timeout, instantiated once.

Verification
REQ-036 req_valid, vend=1, change=00 -> prod_motor high 4 cycles, then done pulse, coin_eject never high.
REQ-037 vend=1, change=10, coin_sense 3 cycles after each eject -> 4-cycle prod_motor, two 4-cycle coin_eject pulses, then done.
REQ-038 vend=0, change=01, no coin_sense -> 3 eject pulses 64 cycles apart, then fault=1; clr_fault -> IDLE, busy=0.
REQ-039 Same as REQ-038 with CHG_RETRY_EN undefined -> one eject pulse, then fault.
REQ-040 coin_sense on the exact timeout cycle -> no retry, done; rst=0 mid-EJECT -> coin_eject=0 in the same cycle, IDLE.
